// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/execute/memory/writeback from Ir,
// owns the architectural status register and the MemRd/MemWr/MemRdy handshake.
module control_fsm #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic [15:0] Ir_i,
    input  logic [3:0]  Flags_i,
    input  logic        MemRdy_i,
    output logic        MemRd_o,
    output logic        MemWr_o,
    output logic        AluEn_o,
    output logic        MemEn_o,
    output logic        StatusRegEn_o,
    output logic [1:0]  AluOR_o,
    output logic        AluWe_o,
    output logic        CFlag_o,
    output logic        ImmSel_o,
    output logic        IrWe_o,
    output logic        LrEn_o,
    output logic        LrSel_o,
    output logic        LrWe_o,
    output logic        Op1Sel_o,
    output logic [1:0]  Op2Sel_o,
    output logic        PcEn_o,
    output logic [2:0]  PcSel_o,
    output logic        PcWe_o,
    output logic        RegWe_o,
    output logic [1:0]  Rs1Sel_o,
    output logic [1:0]  RwSel_o,
    output logic [3:0]  StatusReg_o,
    output logic        WdSel_o
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_RR = 3'b000,
        C_ALU_I5 = 3'b001,
        C_ALU_I8 = 3'b010,
        C_LDW    = 3'b011,
        C_STW    = 3'b100,
        C_BCC    = 3'b101,
        C_LINK   = 3'b110,
        C_MISC   = 3'b111
    } iclass_t;

    localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t        state_q, state_d;
    logic [3:0]    status_q, status_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          active_q;

    iclass_t       cls;
    logic          taken;
    logic          mem_wait;
    logic [CW:0]   wait_nxt;
    logic          wait_hit;
    logic          unused_ir;

    assign cls       = iclass_t'(Ir_i[15:13]);
    assign unused_ir = ^Ir_i[7:0];

    // active_q holds outputs at 0 until the first clock edge after reset, so
    // the first fetch request follows that edge rather than the deassertion.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q  <= S_FETCH;
            status_q <= '0;
            wait_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            wait_q   <= wait_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (Ir_i[11:8])
            4'd0:    taken = 1'b1;
            4'd1:    taken = status_q[2];
            4'd2:    taken = ~status_q[2];
            4'd3:    taken = status_q[1];
            4'd4:    taken = ~status_q[1];
            4'd5:    taken = status_q[3];
            4'd6:    taken = ~status_q[3];
            4'd7:    taken = status_q[0];
            default: taken = 1'b0;
        endcase
    end

    // The count only advances while stalled in FETCH/MEM; any progress or
    // state change lands in the else-branch and clears it.
    always_comb begin
        mem_wait = active_q && ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemRdy_i;
        wait_nxt = {1'b0, wait_q} + {{CW{1'b0}}, 1'b1};
        wait_hit = (WAIT_LIMIT != 0) && mem_wait && (32'(wait_nxt) == WAIT_LIMIT);
        wait_d   = '0;
        if ((WAIT_LIMIT != 0) && mem_wait && !wait_hit) begin
            wait_d = wait_nxt[CW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        MemRd_o  = 1'b0;
        MemWr_o  = 1'b0;
        AluEn_o  = 1'b0;
        MemEn_o  = 1'b0;
        AluWe_o  = 1'b0;
        ImmSel_o = 1'b0;
        IrWe_o   = 1'b0;
        LrSel_o  = 1'b0;
        LrWe_o   = 1'b0;
        Op1Sel_o = 1'b0;
        Op2Sel_o = 2'd0;
        PcSel_o  = 3'd0;
        PcWe_o   = 1'b0;
        RegWe_o  = 1'b0;
        Rs1Sel_o = 2'd0;
        RwSel_o  = 2'd0;
        WdSel_o  = 1'b0;

        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    MemEn_o = 1'b1;
                    MemRd_o = 1'b1;
                    if (MemRdy_i) begin
                        IrWe_o  = 1'b1;
                        PcWe_o  = 1'b1;
                        PcSel_o = 3'd0;
                        state_d = S_EXEC;
                    end else if (wait_hit) begin
                        state_d = S_HALT;
                    end
                end

                S_EXEC: begin
                    case (cls)
                        C_ALU_RR, C_ALU_I5, C_ALU_I8: begin
                            AluWe_o  = 1'b1;
                            RegWe_o  = 1'b1;
                            WdSel_o  = 1'b0;
                            Op2Sel_o = 2'd0;
                            if (cls == C_ALU_RR) begin
                                Op2Sel_o = 2'd1;
                            end else if (cls == C_ALU_I5) begin
                                Rs1Sel_o = 2'd1;
                                RwSel_o  = 2'd1;
                                ImmSel_o = 1'b1;
                            end else begin
                                RwSel_o  = 2'd1;
                            end
                            status_d = Flags_i;
                            state_d  = S_FETCH;
                        end

                        C_LDW, C_STW: begin
                            Rs1Sel_o = 2'd1;
                            ImmSel_o = 1'b1;
                            Op2Sel_o = 2'd0;
                            AluWe_o  = 1'b1;
                            state_d  = S_MEM;
                        end

                        C_BCC: begin
                            Op1Sel_o = 1'b1;
                            Op2Sel_o = 2'd0;
                            ImmSel_o = 1'b0;
                            AluWe_o  = 1'b1;
                            state_d  = taken ? S_WB : S_FETCH;
                        end

                        C_LINK: begin
                            state_d = S_FETCH;
                            case (Ir_i[12:11])
                                2'b00: begin
                                    Op1Sel_o = 1'b1;
                                    AluWe_o  = 1'b1;
                                    LrWe_o   = 1'b1;
                                    LrSel_o  = 1'b1;
                                    state_d  = S_WB;
                                end
                                2'b01: begin
                                    PcWe_o  = 1'b1;
                                    PcSel_o = 3'd3;
                                end
                                2'b10: begin
                                    PcWe_o  = 1'b1;
                                    PcSel_o = 3'd7;
                                end
                                default: ;
                            endcase
                        end

                        default: begin
                            state_d = (Ir_i[12:11] == 2'b11) ? S_HALT : S_FETCH;
                        end
                    endcase
                end

                S_MEM: begin
                    AluEn_o = 1'b1;
                    if (cls == C_LDW) begin
                        MemRd_o = 1'b1;
                    end else begin
                        MemWr_o = 1'b1;
                    end
                    if (MemRdy_i) begin
                        // Load data owns the bus this cycle, so the ALU driver yields.
                        if (cls == C_LDW) begin
                            AluEn_o = 1'b0;
                            MemEn_o = 1'b1;
                            RegWe_o = 1'b1;
                            WdSel_o = 1'b1;
                            RwSel_o = 2'd1;
                        end
                        state_d = S_FETCH;
                    end else if (wait_hit) begin
                        state_d = S_HALT;
                    end
                end

                S_WB: begin
                    PcWe_o  = 1'b1;
                    PcSel_o = 3'd1;
                    state_d = S_FETCH;
                end

                S_HALT: state_d = S_HALT;

                default: state_d = S_FETCH;
            endcase
        end
    end

    assign StatusReg_o   = (active_q && (state_q != S_HALT)) ? status_q : '0;
    assign CFlag_o       = StatusReg_o[1];
    assign StatusRegEn_o = 1'b0;
    assign AluOR_o       = '0;
    assign LrEn_o        = 1'b0;
    assign PcEn_o        = 1'b0;

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multicycle control unit, the instruction-consuming end of the datapath control interface. It reads Ir and Flags from the datapath and drives every datapath control input. It sequences fetch/execute/memory/writeback, holds the architectural status register, and handshakes with memory via MemRd/MemWr/MemRdy.

Parameters:
WAIT_LIMIT, 0, max cycles spent waiting on MemRdy before the unit enters HALT; 0 = wait forever

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high
Ir  in  16  instruction register from datapath
Flags  in  4  combinational ALU flags {N,Z,C,V} = [3:0]
MemRdy  in  1  memory completes current access this cycle
MemRd  out  1  memory read request
MemWr  out  1  memory write request
AluEn, MemEn, StatusRegEn  out  1 each  system-bus driver enables (one-hot or all 0)
AluOR  out  2  ALU carry/override mode; 0 in all states
AluWe  out  1  ALU result register load
CFlag  out  1  = StatusReg[1] (carry into ALU)
ImmSel  out  1  0 = imm8 Ir[7:0], 1 = imm5 Ir[4:0]
IrWe  out  1  instruction register load
LrEn  out  1  tied 0
LrSel  out  1  1 = link register takes return address
LrWe  out  1  link register load
Op1Sel  out  1  0 = Rd1, 1 = Pc
Op2Sel  out  2  0 = Imm, 1 = Rd2, 2 = zero
PcEn  out  1  tied 0
PcSel  out  3  0 = Pc+1, 1 = AluReg, 3 = Lr, 7 = 16'h0010
PcWe  out  1  PC load
RegWe  out  1  register file write
Rs1Sel  out  2  source-1 field select
RwSel  out  2  write-register field select
StatusReg  out  4  architectural {N,Z,C,V}
WdSel  out  1  0 = AluOut, 1 = bus data

Behaviour:
- States: FETCH, EXEC, MEM, WB, HALT. Reset forces FETCH, StatusReg = 0, and all outputs 0.
- All outputs are a Moore decode of state and Ir, except for the PcWe/IrWe qualification on MemRdy.
- Instruction class = Ir[15:13]:
  - 000: ALU reg-reg
  - 001: ALU imm5
  - 010: ALU imm8
  - 011: LDW
  - 100: STW
  - 101: Bcc
  - 110: link group
  - 111: misc
- FETCH:
  - MemEn = 1 and MemRd = 1 throughout.
  - On MemRdy: IrWe = 1, PcWe = 1, PcSel = 0, next state EXEC. Otherwise remain in FETCH.
- EXEC, ALU classes:
  - AluWe = 1, RegWe = 1, WdSel = 0.
  - reg-reg: Rs1Sel = 0, RwSel = 0, Op2Sel = 1.
  - imm5: Rs1Sel = 1, RwSel = 1, ImmSel = 1, Op2Sel = 0.
  - imm8: RwSel = 1, ImmSel = 0, Op2Sel = 0.
  - StatusReg <= Flags at the clock edge.
  - Next state FETCH (2 cycles per ALU instruction with zero wait states).
- LDW and STW:
  - EXEC computes the address: Rs1Sel = 1, ImmSel = 1, Op2Sel = 0, AluWe = 1. Next state MEM.
  - MEM: AluEn = 1 (address/data phase); MemRd = 1 for LDW, MemWr = 1 for STW.
  - LDW on MemRdy: MemEn = 1, RegWe = 1, WdSel = 1, RwSel = 1, then FETCH. STW on MemRdy: FETCH.
- Bcc:
  - Condition field Ir[11:8]: 0 AL, 1 EQ (Z), 2 NE, 3 CS (C), 4 CC, 5 MI (N), 6 PL, 7 VS (V). Values 8-15 are never taken.
  - EXEC: Op1Sel = 1, Op2Sel = 0, ImmSel = 0, AluWe = 1.
  - Condition evaluated on StatusReg. Taken: next state WB, where PcWe = 1, PcSel = 1. Not taken: next state FETCH.
- Link group, Ir[12:11]:
  - 00 BL: EXEC as Bcc with LrWe = 1, LrSel = 1, then WB.
  - 01 RET: EXEC PcWe = 1, PcSel = 3, then FETCH.
  - 10 RST: EXEC PcWe = 1, PcSel = 7, then FETCH.
  - 11: treated as NOP.
- Misc: Ir[12:11] = 11 is HALT; all other values are NOP (EXEC -> FETCH). StatusReg is unchanged for all non-ALU classes.
- HALT: all outputs 0; exited only by Reset.
- Wait counter:
  - Counts consecutive MemRdy = 0 cycles in FETCH/MEM; clears on state change.
  - When WAIT_LIMIT != 0 and the count reaches WAIT_LIMIT, next state is HALT.
- Reset asserted mid-access drops MemRd/MemWr immediately (asynchronous). The first FETCH request follows the first Clock edge after deassertion.
- Bus-enable exclusivity: at most one of AluEn, MemEn, StatusRegEn is 1 in any cycle.

Test Plan:
- Reset -> FETCH with MemRdy=1, Ir=16'h0000 (reg-reg), Flags=4'b0100 -> IrWe/PcWe pulse cycle 1, AluWe/RegWe cycle 2, StatusReg=4'b0100 after.
- LDW Ir=16'h6000, MemRdy held 0 for 3 cycles in MEM -> MemRd stays 1, RegWe=1/WdSel=1 only in the MemRdy cycle, total 3+3 cycles.
- Bcc EQ Ir=16'hA1FE with StatusReg Z=1 -> WB with PcWe=1, PcSel=1; with Z=0 -> FETCH next, PcWe=0.
- BL Ir=16'hC004 -> LrWe=1/LrSel=1 in EXEC, PcSel=1 PcWe=1 in WB; RET Ir=16'hC800 -> PcSel=3.
- WAIT_LIMIT=4, MemRdy stuck 0 in FETCH -> HALT after 4 cycles, all outputs 0 until Reset.
- Reset asserted during MEM of STW -> MemWr falls without clock edge; FETCH resumes, StatusReg=0.
